// File: rtl/dbg_mem_arbiter.sv
// ============================================================================
// Module      : dbg_mem_arbiter
// Description : Round-robin arbiter that shares one memory slave between a
//               CPU port and a debug port. It holds one transaction at a time
//               and adds a one-cycle DONE gap after each completion.
//               Optional slave watchdog: define DBG_MEM_ARBITER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dbg_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_valid,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  input  logic        dbg_mem_op,
  input  logic [31:0] dbg_adr,
  input  logic [31:0] dbg_data,
  input  logic        dbg_RW,
  output logic        dbg_mem_rdy,
  output logic [31:0] dbg_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_DBG = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [31:0] c_TIMEOUT_RDATA = 32'hDEAD_BEEF;

  state_t      r_state;
  state_t      w_state;
  logic        r_last_dbg;     // 1 = debug port was served last
  logic        w_last_dbg;
  logic        w_grant_dbg;
  logic        w_timeout;
  logic        w_mem_valid;
  logic [31:0] w_mem_addr;
  logic [31:0] w_mem_wdata;
  logic [3:0]  w_mem_wstrb;
  logic        w_cpu_ready;
  logic [31:0] w_cpu_rdata;
  logic        w_dbg_mem_rdy;
  logic [31:0] w_dbg_rdata;

  // Reject watchdog limits that do not fit the 16-bit counter.
  generate
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("dbg_mem_arbiter: TIMEOUT_CYCLES must be in 2..65535");
    end
  endgenerate

`ifdef DBG_MEM_ARBITER_TIMEOUT_EN
  localparam logic [15:0] c_WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_wdog;

  // Fires on the edge that ends the TIMEOUT_CYCLES-th cycle of a grant.
  assign w_timeout = (r_wdog == c_WDOG_LAST);

  // Watchdog counts grant cycles and restarts from zero outside a grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog <= 16'd0;
    end else if (r_state == GNT_CPU || r_state == GNT_DBG) begin
      r_wdog <= r_wdog + 16'd1;
    end else begin
      r_wdog <= 16'd0;
    end
  end

  // One-cycle error pulse when a grant is ended by the watchdog.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_err <= 1'b0;
    end else begin
      bus_err <= w_timeout && !mem_ready &&
                 (r_state == GNT_CPU || r_state == GNT_DBG);
    end
  end
`else
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif

  // Next-state and next-output decode; slave fields hold unless a grant loads them.
  always_comb begin
    w_state       = r_state;
    w_last_dbg    = r_last_dbg;
    w_grant_dbg   = 1'b0;
    w_mem_valid   = mem_valid;
    w_mem_addr    = mem_addr;
    w_mem_wdata   = mem_wdata;
    w_mem_wstrb   = mem_wstrb;
    w_cpu_ready   = 1'b0;
    w_cpu_rdata   = 32'd0;
    w_dbg_mem_rdy = 1'b0;
    w_dbg_rdata   = 32'd0;
    case (r_state)
      IDLE: begin
        // On a tie the port not served last wins.
        w_grant_dbg = dbg_mem_op && (!cpu_valid || !r_last_dbg);
        if (w_grant_dbg) begin
          w_state     = GNT_DBG;
          w_mem_valid = 1'b1;
          w_mem_addr  = dbg_adr;
          w_mem_wdata = dbg_data;
          w_mem_wstrb = dbg_RW ? 4'b0000 : 4'b1111;
        end else if (cpu_valid) begin
          w_state     = GNT_CPU;
          w_mem_valid = 1'b1;
          w_mem_addr  = cpu_addr;
          w_mem_wdata = cpu_wdata;
          w_mem_wstrb = cpu_wstrb;
        end
      end
      GNT_CPU: begin
        if (mem_ready || w_timeout) begin
          w_state     = DONE;
          w_mem_valid = 1'b0;
          w_cpu_ready = 1'b1;
          w_cpu_rdata = mem_ready ? mem_rdata : c_TIMEOUT_RDATA;
          w_last_dbg  = 1'b0;
        end
      end
      GNT_DBG: begin
        if (mem_ready || w_timeout) begin
          w_state       = DONE;
          w_mem_valid   = 1'b0;
          w_dbg_mem_rdy = 1'b1;
          w_dbg_rdata   = mem_ready ? mem_rdata : c_TIMEOUT_RDATA;
          w_last_dbg    = 1'b1;
        end
      end
      DONE: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  // State, arbitration history and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last_dbg  <= 1'b0;
      mem_valid   <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      mem_wstrb   <= 4'd0;
      cpu_ready   <= 1'b0;
      cpu_rdata   <= 32'd0;
      dbg_mem_rdy <= 1'b0;
      dbg_rdata   <= 32'd0;
    end else begin
      r_state     <= w_state;
      r_last_dbg  <= w_last_dbg;
      mem_valid   <= w_mem_valid;
      mem_addr    <= w_mem_addr;
      mem_wdata   <= w_mem_wdata;
      mem_wstrb   <= w_mem_wstrb;
      cpu_ready   <= w_cpu_ready;
      cpu_rdata   <= w_cpu_rdata;
      dbg_mem_rdy <= w_dbg_mem_rdy;
      dbg_rdata   <= w_dbg_rdata;
    end
  end

endmodule

`default_nettype wire

// File: doc/dbg_mem_arbiter.md
DBG_MEM_ARBITER -- requirements
Module: dbg_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: slave-response watchdog limit in clk cycles, range 2..65535.
REQ-002 SHALL have ports, clock and reset first, name  direction  width  meaning:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_valid  in  1  CPU request, level held until cpu_ready.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data.
- cpu_wstrb  in  4  CPU byte enables; 0 = read.
- cpu_ready  out  1  one-cycle CPU completion pulse.
- cpu_rdata  out  32  CPU read data, valid with cpu_ready.
- dbg_mem_op  in  1  debug request, level held until dbg_mem_rdy.
- dbg_adr  in  32  debug address.
- dbg_data  in  32  debug write data.
- dbg_RW  in  1  1 = read, 0 = write (all 4 bytes).
- dbg_mem_rdy  out  1  one-cycle debug completion pulse.
- dbg_rdata  out  32  debug read data, valid with dbg_mem_rdy.
- mem_valid  out  1  slave request.
- mem_addr  out  32  slave address.
- mem_wdata  out  32  slave write data.
- mem_wstrb  out  4  slave byte enables.
- mem_ready  in  1  slave completion.
- mem_rdata  in  32  slave read data.
- bus_err  out  1  one-cycle timeout pulse (macro-dependent).

Function
REQ-003 SHALL implement states IDLE, GNT_CPU, GNT_DBG, DONE.
REQ-004 In IDLE: if exactly one of cpu_valid/dbg_mem_op is high, SHALL enter the matching GNT state next edge.
REQ-005 In IDLE with both requests high, SHALL grant the requester not served last (round-robin); after reset the debug port wins the first tie.
REQ-006 On entering GNT_x, SHALL register mem_addr/mem_wdata/mem_wstrb from the granted port and assert mem_valid; grant latency: request high to mem_valid high = 1 cycle.
REQ-007 Debug mapping: mem_wstrb = 4'b0000 when dbg_RW=1, 4'b1111 when dbg_RW=0.
REQ-008 Address, data and strobe outputs SHALL stay stable while mem_valid is high.
REQ-009 In GNT_x with mem_ready high: SHALL clear mem_valid, pulse the granted port's ready for exactly one cycle with rdata = mem_rdata captured that edge, update the last-served record, and go to DONE.
REQ-010 DONE SHALL last exactly one cycle, then go to IDLE; this lets the requester drop its level request and prevents a double grant.
REQ-011 A request that goes high while the other port is granted SHALL wait; grant is never pre-empted mid-transaction.
REQ-012 Ready/rdata of the non-granted port SHALL stay 0.
REQ-013 mem_ready while in IDLE or DONE SHALL be ignored.
REQ-014 Back-to-back CPU requests with no debug activity: throughput SHALL be one transaction per (slave latency + 3) cycles.

Reset
REQ-015 Asserting reset SHALL immediately (asynchronously) set state IDLE, mem_valid 0, mem_addr/mem_wdata 0, mem_wstrb 0, cpu_ready 0, dbg_mem_rdy 0, cpu_rdata 0, dbg_rdata 0, bus_err 0, last-served = CPU, watchdog 0.
REQ-016 Reset mid-transaction SHALL abandon the transaction with no ready pulse to either port.

Configuration
REQ-017 Macro DBG_MEM_ARBITER_TIMEOUT_EN defined: a 16-bit watchdog counts cycles in GNT_x. If it reaches TIMEOUT_CYCLES without mem_ready, the arbiter SHALL drop mem_valid, pulse the granted port's ready with rdata 32'hDEADBEEF, pulse bus_err for one cycle, and go to DONE. The watchdog clears on every entry to GNT_x.
REQ-018 Macro undefined: no watchdog logic; GNT_x waits indefinitely; bus_err is tied 0.

Verification
REQ-019 CPU read alone: addr 0x100, slave mem_ready 2 cycles after mem_valid, mem_rdata 0x12345678 -> mem_valid 1 cycle after cpu_valid, single cpu_ready pulse with cpu_rdata 0x12345678, dbg_mem_rdy stays 0.
REQ-020 Debug write: dbg_adr 0x200, dbg_data 0xCAFEBABE, dbg_RW 0 -> mem_wstrb 4'hF, mem_wdata 0xCAFEBABE, one dbg_mem_rdy pulse, DONE gap before any new mem_valid.
REQ-021 Simultaneous requests after reset -> debug granted first, then CPU; a repeated tie -> CPU first, then debug (alternation).
REQ-022 Debug request arriving during a CPU grant with 5-cycle slave latency -> CPU completes unaltered; debug mem_valid follows after the DONE and IDLE cycles.
REQ-023 With DBG_MEM_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never ready -> after 8 cycles: cpu_ready pulse, cpu_rdata 0xDEADBEEF, bus_err pulse; without the macro -> mem_valid held indefinitely.
REQ-024 Reset asserted 2 cycles into a debug grant -> all outputs 0 on the same edge, no dbg_mem_rdy; a fresh CPU request after release is served normally.
